// File: rtl/spart_key_rx_if.sv
// spart_key_rx_if: receiver-to-CPU key bus.
//   SPART_we     - one-cycle strobe, mapped key received
//   SPART_keys   - 4-bit key code, holds last mapped key
//   rx_byte      - last correctly framed byte
//   rx_byte_vld  - one-cycle strobe per correctly framed byte
//   frame_err    - one-cycle strobe on bad stop bit (or parity error)
// master: the receiver drives; slave: the CPU side observes.
interface spart_key_rx_if;
  logic       SPART_we;
  logic [3:0] SPART_keys;
  logic [7:0] rx_byte;
  logic       rx_byte_vld;
  logic       frame_err;

  modport master (
    output SPART_we,
    output SPART_keys,
    output rx_byte,
    output rx_byte_vld,
    output frame_err
  );

  modport slave (
    input SPART_we,
    input SPART_keys,
    input rx_byte,
    input rx_byte_vld,
    input frame_err
  );
endinterface

// File: rtl/spart_key_rx.sv
// spart_key_rx: serial keyboard receiver for the CPU SPART input port.
// Deserialises UART frames on rxd (8N1, or 8E1 when SPART_RX_PARITY_EN is
// defined), maps recognised ASCII bytes to 4-bit key codes and strobes them
// to the CPU.
//   clk  - system clock (rising edge)
//   rst  - synchronous active-high reset
//   rxd  - asynchronous serial line, idle high
//   bus  - spart_key_rx_if.master: SPART_we, SPART_keys, rx_byte,
//          rx_byte_vld, frame_err (all registered)
// Parameter CLK_PER_BIT: clocks per bit period, 4..65535.
module spart_key_rx #(
  parameter int unsigned CLK_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  spart_key_rx_if.master    bus
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  // Byte-to-key map; 0 means unmapped.
  function automatic logic [3:0] key_map(input logic [7:0] b);
    case (b)
      8'h77, 8'h57: key_map = 4'h1;
      8'h73, 8'h53: key_map = 4'h2;
      8'h61, 8'h41: key_map = 4'h3;
      8'h64, 8'h44: key_map = 4'h4;
      8'h71, 8'h51: key_map = 4'h5;
      8'h65, 8'h45: key_map = 4'h6;
      8'h72, 8'h52: key_map = 4'h7;
      8'h20:        key_map = 4'h8;
      8'h0D:        key_map = 4'h9;
      8'h1B:        key_map = 4'hF;
      default:      key_map = 4'h0;
    endcase
  endfunction

  logic             sync1_q, sync1_d;
  logic             rxs_q, rxs_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             done_ok_q, done_ok_d;
  logic             done_err_q, done_err_d;
`ifdef SPART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
`endif
  logic             we_q, we_d;
  logic [3:0]       keys_q, keys_d;
  logic [7:0]       byte_q, byte_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;

  logic             expire_c;
  logic [3:0]       key_c;

  // Next-state, datapath and output-stage logic.
  always_comb begin
    sync1_d    = rxd;
    rxs_d      = sync1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    done_ok_d  = 1'b0;
    done_err_d = 1'b0;
`ifdef SPART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
`endif
    expire_c   = (cnt_q == CNT_W'(1));
    key_c      = key_map(shift_q);

    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          cnt_d   = CNT_HALF;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (expire_c) begin
          if (rxs_q) begin
            state_d = ST_IDLE;             // false start
          end else begin
            cnt_d     = CNT_FULL;
            bit_idx_d = 3'd0;
            state_d   = ST_DATA;
          end
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      ST_DATA: begin
        if (expire_c) begin
          shift_d   = {rxs_q, shift_q[7:1]};   // LSB first
          cnt_d     = CNT_FULL;
          bit_idx_d = 3'(bit_idx_q + 3'd1);
          if (bit_idx_q == 3'd7) begin
`ifdef SPART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
`ifdef SPART_RX_PARITY_EN
      ST_PARITY: begin
        if (expire_c) begin
          par_bad_d = ^{shift_q, rxs_q};   // even parity check
          cnt_d     = CNT_FULL;
          state_d   = ST_STOP;
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
`endif
      ST_STOP: begin
        if (expire_c) begin
          if (rxs_q) begin
            state_d = ST_IDLE;
`ifdef SPART_RX_PARITY_EN
            done_ok_d  = !par_bad_q;
            done_err_d = par_bad_q;
`else
            done_ok_d  = 1'b1;
`endif
          end else begin
            done_err_d = 1'b1;
            state_d    = ST_BREAK;
          end
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      ST_BREAK: begin
        if (rxs_q) state_d = ST_IDLE;    // one error per held-low line
      end
      default: state_d = ST_IDLE;
    endcase

    // Output stage: one clock after the stop-bit sample. shift_q is stable
    // here since the next frame cannot have sampled data yet.
    vld_d  = done_ok_q;
    err_d  = done_err_q;
    byte_d = done_ok_q ? shift_q : byte_q;
    we_d   = done_ok_q && (key_c != 4'h0);
    keys_d = (done_ok_q && (key_c != 4'h0)) ? key_c : keys_q;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      done_ok_q  <= 1'b0;
      done_err_q <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
`endif
      we_q       <= 1'b0;
      keys_q     <= '0;
      byte_q     <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      rxs_q      <= rxs_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      done_ok_q  <= done_ok_d;
      done_err_q <= done_err_d;
`ifdef SPART_RX_PARITY_EN
      par_bad_q  <= par_bad_d;
`endif
      we_q       <= we_d;
      keys_q     <= keys_d;
      byte_q     <= byte_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
    end
  end

  assign bus.SPART_we    = we_q;
  assign bus.SPART_keys  = keys_q;
  assign bus.rx_byte     = byte_q;
  assign bus.rx_byte_vld = vld_q;
  assign bus.frame_err   = err_q;

endmodule

// File: doc/spart_key_rx.md
# spart_key_rx

Serial keyboard receiver feeding the CPU's SPART input port. Deserialises 8N1 UART frames from the host link on `rxd`, maps recognised ASCII characters to 4-bit key codes, and presents each key to the CPU as a one-cycle `SPART_we` strobe with `SPART_keys`. Sits between the board RX pin and `cpu`. Malformed frames and unmapped characters never reach the CPU.

## Interface
- `CLK_PER_BIT`, 434, clock cycles per bit period (50 MHz / 115200); legal range 4..65535.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rxd` input 1: asynchronous serial line; idle high.
- `SPART_we` output 1: one-cycle strobe when a mapped key is received.
- `SPART_keys` output 4: key code; holds the last mapped key.
- `rx_byte` output 8: last byte received with correct framing.
- `rx_byte_vld` output 1: one-cycle strobe for every correctly framed byte, mapped or not.
- `frame_err` output 1: one-cycle strobe on a bad stop bit (or a parity error, see Configuration).

## Operation
- `rxd` passes through a 2-flop synchroniser initialised to 1. All of the following uses the synchronised value `rxs`.
- The state machine has these states:
  - IDLE: when `rxs`=0, load the counter with `CLK_PER_BIT/2` (integer division) and go to START.
  - START: when the count expires, resample. If `rxs`=1 this is a false start; go to IDLE with no output. Otherwise go to DATA with the count at `CLK_PER_BIT` and the bit index at 0.
  - DATA: sample at each expiry. Bits arrive LSB first into a shift register. After bit 7, go to STOP (or PARITY when configured).
  - STOP: sample. If `rxs`=1 the frame completes; return to IDLE. If `rxs`=0, pulse `frame_err` and go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. This means a held-low line produces exactly one `frame_err`.
- The counter is 16 bits and counts down to 1 inclusive; expiry is defined as count==1.
- Key map (exact byte to code):
  - 'w'/'W' (0x77/0x57) → 0x1
  - 's'/'S' → 0x2
  - 'a'/'A' → 0x3
  - 'd'/'D' → 0x4
  - 'q'/'Q' → 0x5
  - 'e'/'E' → 0x6
  - 'r'/'R' → 0x7
  - space 0x20 → 0x8
  - CR 0x0D → 0x9
  - ESC 0x1B → 0xF
  - All other bytes are unmapped: no `SPART_we`, and `SPART_keys` is unchanged.
- Code 0x0 is never produced.

## Timing
- Reset values: `SPART_we`=0, `SPART_keys`=0x0, `rx_byte`=0x00, `rx_byte_vld`=0, `frame_err`=0, state IDLE, synchroniser flops =1.
- Latency from the stop-bit sample edge:
  - `rx_byte` and `rx_byte_vld` update on the next clock edge.
  - `SPART_we` and `SPART_keys` update on the same edge as `rx_byte_vld`.
  - All strobes last exactly one cycle.
- Sample points fall `CLK_PER_BIT/2 + k*CLK_PER_BIT` cycles after the synchronised falling edge of the start bit.
- A new start bit is accepted in the cycle after STOP returns to IDLE. Back-to-back frames with zero idle time are received without loss.
- The CPU has no backpressure and the block has no buffering. Each key is presented once; the CPU latches it on `SPART_we`.
- Asserting `rst` mid-frame aborts the frame with no strobes and returns to IDLE on the next edge. A partially received frame after reset is treated as line noise: if `rxs` is low when reset releases, it is taken as a start bit.

## Configuration
- `SPART_RX_PARITY_EN`:
  - When defined: frames are 8E1. The state machine inserts a PARITY state after DATA that samples one bit. A parity mismatch (XOR of the 8 data bits and the parity bit ≠ 0) pulses `frame_err` at the stop-bit result time. The byte is then discarded: no `rx_byte_vld` and no `SPART_we`.
  - When undefined: frames are 8N1 and no PARITY state exists.

## Test plan
- Reset with `CLK_PER_BIT`=8. Send 'w' (0x77) as 8N1 → exactly one `SPART_we` with `SPART_keys`=0x1 and `rx_byte`=0x77, about 76 cycles after the start edge.
- Send 'd' then 'x' (0x78) back-to-back with no idle time → `SPART_we`/0x4 for 'd'. For 'x', `rx_byte_vld` with `rx_byte`=0x78, no `SPART_we`, and `SPART_keys` stays 0x4.
- Send a 2-cycle low glitch on `rxd` → no strobes, state returns to IDLE, and a following 'a' yields `SPART_keys`=0x3.
- Send 0x20 with the stop bit forced to 0, then hold `rxd` low for 40 cycles → one `frame_err` pulse and no `SPART_we`. After release, ESC (0x1B) yields `SPART_keys`=0xF.
- Assert `rst` during bit 4 of 'q' → no strobes and outputs return to reset values. A following 'q' yields `SPART_keys`=0x5.
- With `SPART_RX_PARITY_EN` defined: 'e' (0x65) with correct even parity → `SPART_keys`=0x6. 'e' with the parity bit inverted → `frame_err`, and neither `rx_byte_vld` nor `SPART_we`.
